seq_ctrl_timed: RTL and testbench
=================================

Name: seq_ctrl_timed

Overview:
- Parametrised successor to the board-level LED sequence controller.
- Runs one clock domain. An internal tick prescaler produces a clock enable, so the state machine is no longer clocked from a divided signal.
- Inputs are active-low: a start switch, an acknowledge switch and N trigger switches.
- Sequence: arm delay, wait for trigger, hold window, run window. An abort path is taken when K or more triggers are asserted together. LED pattern and state are exported for board and simulation.

Parameters:
- TICK_DIV, 12000: CLK cycles per tick (1 ms at 12 MHz); must be >= 2.
- TIM_W, 16: timer width in bits.
- T_ARM, 2000: ARM duration in ticks; >= 1.
- T_HOLD, 1000: HOLD window in ticks; >= 1.
- T_RUN, 5000: RUN window in ticks; >= 1.
- N_TRIG, 2: number of trigger inputs; 1..8.
- K_ABORT, 2: count of simultaneously asserted triggers that forces ABORT; 1..N_TRIG.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  synchronous reset, active-low.
- START_N  in  1  start/confirm switch, active-low, already debounced.
- ACK_N  in  1  acknowledge switch, active-low.
- TRIG_N  in  N_TRIG  trigger switches, active-low.
- LED  out  4  state pattern, registered.
- STATE  out  3  current state code, registered.
- TICK  out  1  one-cycle tick pulse.
- TIM  out  TIM_W  current timer value.

Behaviour:
- Reset (RST_N=0 at posedge CLK): state IDLE, LED=0000, STATE=0, TIM=0, prescaler=0, TICK=0. Reset mid-sequence aborts immediately; there are no pending timer effects.
- Prescaler counts 0..TICK_DIV-1. TICK=1 for exactly one cycle when the count is TICK_DIV-1, then it wraps to 0.
- FSM and timer update only on cycles where TICK=1. All inputs are sampled on that cycle.
- Derived signals: act = ~TRIG_N; any = |act; cnt = popcount(act), width clog2(N_TRIG+1); abort = cnt >= K_ABORT.
- Timer rule per tick: a transition that loads T writes T-1. Otherwise, if TIM != 0, TIM decrements. A load overrides the decrement on the same tick.
- "Expired" means TIM == 0 on the evaluated tick, so a state entered with load T lasts exactly T ticks.
- States (code / LED / transitions):
  - IDLE 0 / 0000: START_N=0 -> ARM, load T_ARM.
  - ARM 1 / 0001: expired -> READY.
  - READY 2 / 0011: abort -> ABORT. Otherwise any -> HOLD, load T_HOLD.
  - HOLD 3 / 0011: expired -> RUN, load T_RUN. Otherwise abort -> ABORT. Expiry has priority over abort.
  - RUN 4 / 0111: expired -> DONE. Otherwise abort -> ABORT.
  - ABORT 5 / 1011: ACK_N=0 -> LATCH.
  - LATCH 6 / 1011: START_N=0 -> DONE.
  - DONE 7 / 0000: ACK_N=0 -> IDLE.
- LED and STATE are registered from next-state, so both change in the same cycle the state changes (latency 1 CLK after the tick edge).
- TIM is exported with no extra delay.
- Inputs held low persist across states. Example: START_N held low through LATCH->DONE does not retrigger ARM until DONE->IDLE->next tick.
- Timer width: loads are truncated to TIM_W. An elaboration-time check fails if any T_* >= 2^TIM_W or is 0.

Optional Feature:
- Macro SEQ_CTRL_INPUT_SYNC_EN.
- Defined: each of START_N, ACK_N and TRIG_N passes a 2-flop synchroniser before use, adding 2 CLK of input latency. The synchroniser flops reset to 1 (inactive).
- Undefined: inputs are used directly and must already be synchronous (debouncer output).

Decomposition:
- Shared package seq_ctrl_pkg: state encoding constants (S_IDLE..S_DONE = 0..7), LED pattern constants per state, popcount function.
- One sub-module: tick_gen (prescaler, params TICK_DIV; ports CLK, RST_N, TICK).
- FSM, timer and abort logic stay in the top module.

Test Plan (TICK_DIV=4, T_ARM=3, T_HOLD=2, T_RUN=4, N_TRIG=2, K_ABORT=2):
- Nominal path:
  - Stimulus: START_N=0 one tick -> ARM, LED=0001 for 3 ticks, then READY.
  - Stimulus: TRIG_N=10 (one trigger) -> HOLD 2 ticks -> RUN LED=0111 4 ticks -> DONE LED=0000.
  - Stimulus: ACK_N=0 -> IDLE.
  - Required: TICK period is 4 CLK throughout.
- Abort in RUN: TRIG_N=00 on 2nd RUN tick -> ABORT, LED=1011. Then ACK_N=0 -> LATCH; START_N=0 -> DONE.
- Simultaneous: TRIG_N=00 on the HOLD tick where TIM==0 -> RUN (expiry wins), TIM=3.
- Reset mid-RUN with TIM=2: RST_N=0 one CLK -> next cycle STATE=0, LED=0000, TIM=0, TICK low for the next 3 CLK.
- Inputs between ticks: START_N pulsed low for 2 CLK not overlapping a TICK -> remains IDLE.
- With SEQ_CTRL_INPUT_SYNC_EN: START_N falls 1 CLK before a tick -> ARM entered one tick later than without the macro.

Source files
------------

// File: rtl/seq_ctrl_pkg.sv
// Shared definitions for seq_ctrl_timed: state codes, LED patterns per state,
// and a trigger popcount helper.
package seq_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_READY = 3'd2,
        S_HOLD  = 3'd3,
        S_RUN   = 3'd4,
        S_ABORT = 3'd5,
        S_LATCH = 3'd6,
        S_DONE  = 3'd7
    } state_e;

    localparam logic [3:0] LED_IDLE  = 4'b0000;
    localparam logic [3:0] LED_ARM   = 4'b0001;
    localparam logic [3:0] LED_READY = 4'b0011;
    localparam logic [3:0] LED_HOLD  = 4'b0011;
    localparam logic [3:0] LED_RUN   = 4'b0111;
    localparam logic [3:0] LED_ABORT = 4'b1011;
    localparam logic [3:0] LED_LATCH = 4'b1011;
    localparam logic [3:0] LED_DONE  = 4'b0000;

    function automatic logic [3:0] led_of(input state_e s);
        logic [3:0] led;
        unique case (s)
            S_IDLE:  led = LED_IDLE;
            S_ARM:   led = LED_ARM;
            S_READY: led = LED_READY;
            S_HOLD:  led = LED_HOLD;
            S_RUN:   led = LED_RUN;
            S_ABORT: led = LED_ABORT;
            S_LATCH: led = LED_LATCH;
            S_DONE:  led = LED_DONE;
        endcase
        return led;
    endfunction

    // Up to 8 triggers; narrower vectors are zero-extended by the caller.
    function automatic int unsigned popcount(input logic [7:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            n += 32'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Tick prescaler: counts 0..TICK_DIV-1 and flags the last count as a
// one-cycle clock enable for the sequencer.
module tick_gen #(
    parameter int unsigned TICK_DIV = 12000
) (
    input  logic CLK,
    input  logic RST_N,
    output logic TICK
);

    localparam int unsigned CntW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TICK_DIV - 1);

    if (TICK_DIV < 2) begin : g_bad_div
        $error("tick_gen: TICK_DIV must be >= 2");
    end

    logic [CntW-1:0] cnt_q;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            cnt_q <= '0;
        end else if (cnt_q == CntLast) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CntW'(1);
        end
    end

    assign TICK = (cnt_q == CntLast);

endmodule

// File: rtl/seq_ctrl_timed.sv
// Timed LED sequence controller: arm, wait for trigger, hold, run, with an
// abort path. Optional input synchronisers via SEQ_CTRL_INPUT_SYNC_EN.
module seq_ctrl_timed #(
    parameter int unsigned TICK_DIV = 12000,
    parameter int unsigned TIM_W    = 16,
    parameter int unsigned T_ARM    = 2000,
    parameter int unsigned T_HOLD   = 1000,
    parameter int unsigned T_RUN    = 5000,
    parameter int unsigned N_TRIG   = 2,
    parameter int unsigned K_ABORT  = 2
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              START_N,
    input  logic              ACK_N,
    input  logic [N_TRIG-1:0] TRIG_N,
    output logic [3:0]        LED,
    output logic [2:0]        STATE,
    output logic              TICK,
    output logic [TIM_W-1:0]  TIM
);

    import seq_ctrl_pkg::*;

    localparam longint unsigned TimLimit = 64'd1 << TIM_W;
    localparam int unsigned CntW = $clog2(N_TRIG + 1);

    if (T_ARM == 0 || T_HOLD == 0 || T_RUN == 0 ||
        64'(T_ARM) >= TimLimit || 64'(T_HOLD) >= TimLimit || 64'(T_RUN) >= TimLimit)
    begin : g_bad_timer
        $error("seq_ctrl_timed: T_ARM/T_HOLD/T_RUN must be in 1..2^TIM_W-1");
    end
    if (N_TRIG < 1 || N_TRIG > 8 || K_ABORT < 1 || K_ABORT > N_TRIG) begin : g_bad_trig
        $error("seq_ctrl_timed: need 1 <= K_ABORT <= N_TRIG <= 8");
    end

    // Loads store T-1 so that a state entered with load T lasts T ticks.
    localparam logic [TIM_W-1:0] LdArm  = TIM_W'(T_ARM - 1);
    localparam logic [TIM_W-1:0] LdHold = TIM_W'(T_HOLD - 1);
    localparam logic [TIM_W-1:0] LdRun  = TIM_W'(T_RUN - 1);

    logic              tick;
    logic              start_n_s;
    logic              ack_n_s;
    logic [N_TRIG-1:0] trig_n_s;

    tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_gen (
        .CLK  (CLK),
        .RST_N(RST_N),
        .TICK (tick)
    );

`ifdef SEQ_CTRL_INPUT_SYNC_EN
    logic [1:0]        start_sync_q;
    logic [1:0]        ack_sync_q;
    logic [N_TRIG-1:0] trig_s1_q;
    logic [N_TRIG-1:0] trig_s2_q;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            start_sync_q <= 2'b11;
            ack_sync_q   <= 2'b11;
            trig_s1_q    <= '1;
            trig_s2_q    <= '1;
        end else begin
            start_sync_q <= {start_sync_q[0], START_N};
            ack_sync_q   <= {ack_sync_q[0], ACK_N};
            trig_s1_q    <= TRIG_N;
            trig_s2_q    <= trig_s1_q;
        end
    end

    assign start_n_s = start_sync_q[1];
    assign ack_n_s   = ack_sync_q[1];
    assign trig_n_s  = trig_s2_q;
`else
    assign start_n_s = START_N;
    assign ack_n_s   = ACK_N;
    assign trig_n_s  = TRIG_N;
`endif

    logic [N_TRIG-1:0] act;
    logic [CntW-1:0]   act_cnt;
    logic              any_trig;
    logic              abort;

    assign act      = ~trig_n_s;
    assign any_trig = |act;
    assign act_cnt  = CntW'(popcount(8'(act)));
    assign abort    = 32'(act_cnt) >= K_ABORT;

    state_e           state_q, state_d;
    logic [3:0]       led_q, led_d;
    logic [TIM_W-1:0] tim_q, tim_d;
    logic             load;
    logic [TIM_W-1:0] load_val;
    logic             expired;

    assign expired = (tim_q == '0);

    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        load_val = '0;
        if (tick) begin
            unique case (state_q)
                S_IDLE: begin
                    if (!start_n_s) begin
                        state_d  = S_ARM;
                        load     = 1'b1;
                        load_val = LdArm;
                    end
                end
                S_ARM: begin
                    if (expired) state_d = S_READY;
                end
                S_READY: begin
                    if (abort) begin
                        state_d = S_ABORT;
                    end else if (any_trig) begin
                        state_d  = S_HOLD;
                        load     = 1'b1;
                        load_val = LdHold;
                    end
                end
                S_HOLD: begin
                    // Expiry outranks a simultaneous abort.
                    if (expired) begin
                        state_d  = S_RUN;
                        load     = 1'b1;
                        load_val = LdRun;
                    end else if (abort) begin
                        state_d = S_ABORT;
                    end
                end
                S_RUN: begin
                    if (expired) begin
                        state_d = S_DONE;
                    end else if (abort) begin
                        state_d = S_ABORT;
                    end
                end
                S_ABORT: begin
                    if (!ack_n_s) state_d = S_LATCH;
                end
                S_LATCH: begin
                    if (!start_n_s) state_d = S_DONE;
                end
                S_DONE: begin
                    if (!ack_n_s) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end

        tim_d = tim_q;
        if (tick) begin
            if (load) begin
                tim_d = load_val;
            end else if (!expired) begin
                tim_d = tim_q - TIM_W'(1);
            end
        end

        led_d = led_of(state_d);
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            led_q   <= LED_IDLE;
            tim_q   <= '0;
        end else begin
            state_q <= state_d;
            led_q   <= led_d;
            tim_q   <= tim_d;
        end
    end

    assign STATE = state_q;
    assign LED   = led_q;
    assign TIM   = tim_q;
    assign TICK  = tick;

endmodule

// File: tb/tb_seq_ctrl_timed.sv
// Bench for seq_ctrl_timed: directed scenarios plus randomized inputs checked
// against a tick-level reference model of the sequence rules.
module tb_seq_ctrl_timed;

    localparam int unsigned TD = 4;
    localparam int unsigned TW = 8;
    localparam int unsigned TA = 3;
    localparam int unsigned TH = 2;
    localparam int unsigned TR = 4;
    localparam int unsigned NT = 2;
    localparam int unsigned KA = 2;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          START_N = 1'b1;
    logic          ACK_N = 1'b1;
    logic [NT-1:0] TRIG_N = '1;
    logic [3:0]    LED;
    logic [2:0]    STATE;
    logic          TICK;
    logic [TW-1:0] TIM;

    seq_ctrl_timed #(
        .TICK_DIV(TD), .TIM_W(TW), .T_ARM(TA), .T_HOLD(TH), .T_RUN(TR),
        .N_TRIG(NT), .K_ABORT(KA)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .START_N(START_N), .ACK_N(ACK_N), .TRIG_N(TRIG_N),
        .LED(LED), .STATE(STATE), .TICK(TICK), .TIM(TIM)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: state code, timer, prescaler count, and whether the
    // last edge was a tick edge.
    int m_state = 0;
    int m_tim = 0;
    int m_cnt = 0;
    bit m_ticked = 1'b0;
    logic [3:0] led_tab [8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0011,
                                4'b0111, 4'b1011, 4'b1011, 4'b0000};
`ifdef SEQ_CTRL_INPUT_SYNC_EN
    logic [1:0]    sy_start = 2'b11;
    logic [1:0]    sy_ack = 2'b11;
    logic [NT-1:0] sy_trig0 = '1;
    logic [NT-1:0] sy_trig1 = '1;
`endif

    typedef struct {
        bit         s;
        bit         a;
        logic [1:0] t;
        int         st;
        int         tm;
    } row_t;

    function automatic void model_tick(input bit start, input bit ack, input logic [NT-1:0] act);
        int  ns;
        int  ld;
        bit  ab;
        bit  ex;
        ns = m_state;
        ld = 0;
        ab = ($countones(act) >= KA);
        ex = (m_tim == 0);
        case (m_state)
            0: if (start) begin ns = 1; ld = TA; end
            1: if (ex) ns = 2;
            2: if (ab) ns = 5; else if (act != 0) begin ns = 3; ld = TH; end
            3: if (ex) begin ns = 4; ld = TR; end else if (ab) ns = 5;
            4: if (ex) ns = 7; else if (ab) ns = 5;
            5: if (ack) ns = 6;
            6: if (start) ns = 7;
            default: if (ack) ns = 0;
        endcase
        m_tim = (ld != 0) ? ld - 1 : ((m_tim != 0) ? m_tim - 1 : 0);
        m_state = ns;
    endfunction

    task automatic model_edge();
        bit            es;
        bit            ea;
        logic [NT-1:0] et;
        if (!RST_N) begin
            m_state = 0; m_tim = 0; m_cnt = 0; m_ticked = 1'b0;
`ifdef SEQ_CTRL_INPUT_SYNC_EN
            sy_start = 2'b11; sy_ack = 2'b11; sy_trig0 = '1; sy_trig1 = '1;
`endif
        end else begin
`ifdef SEQ_CTRL_INPUT_SYNC_EN
            es = sy_start[1]; ea = sy_ack[1]; et = sy_trig1;
            sy_start = {sy_start[0], START_N};
            sy_ack = {sy_ack[0], ACK_N};
            sy_trig1 = sy_trig0;
            sy_trig0 = TRIG_N;
`else
            es = START_N; ea = ACK_N; et = TRIG_N;
`endif
            m_ticked = (m_cnt == TD - 1);
            if (m_ticked) model_tick(!es, !ea, ~et);
            m_cnt = (m_cnt + 1) % TD;
        end
    endtask

    task automatic clk_cycle();
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    task automatic to_tick();
        for (int i = 0; i < TD + 1; i++) begin
            clk_cycle();
            if (m_ticked) break;
        end
    endtask

    // Present inputs for exactly one tick evaluation, then release them.
    task automatic tick_with(input bit s, input bit a, input logic [1:0] t);
        START_N = s; ACK_N = a; TRIG_N = t;
        to_tick();
        START_N = 1'b1; ACK_N = 1'b1; TRIG_N = '1;
    endtask

    task automatic go_hold();
        tick_with(1'b0, 1'b1, 2'b11);
        for (int i = 0; i < 3; i++) tick_with(1'b1, 1'b1, 2'b11);
        tick_with(1'b1, 1'b1, 2'b10);
        tick_with(1'b1, 1'b1, 2'b11);
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        clk_cycle();
        clk_cycle();
        n_vec++;
        if ({STATE, LED, TIM, TICK} !== '0) begin
            n_err++;
            $display("FAIL reset: got state=%0d led=%b tim=%0d tick=%b, want all zero",
                     STATE, LED, TIM, TICK);
        end
        RST_N = 1'b1;
    endtask

    task automatic test_tick_period();
        int k;
        to_tick();
        for (int j = 0; j < 3; j++) begin
            k = 0;
            do begin
                clk_cycle();
                k++;
            end while (TICK !== 1'b1 && k < 10);
            n_vec++;
            if (k != ((j == 0) ? TD - 1 : TD)) begin
                n_err++;
                $display("FAIL tick_period[%0d]: got %0d CLK, want %0d", j, k,
                         (j == 0) ? TD - 1 : TD);
            end
        end
        to_tick();
    endtask

    task automatic test_nominal();
        row_t rows [12] = '{
            '{1'b0, 1'b1, 2'b11, 1, 2}, '{1'b1, 1'b1, 2'b11, 1, 1},
            '{1'b1, 1'b1, 2'b11, 1, 0}, '{1'b1, 1'b1, 2'b11, 2, 0},
            '{1'b1, 1'b1, 2'b10, 3, 1}, '{1'b1, 1'b1, 2'b11, 3, 0},
            '{1'b1, 1'b1, 2'b11, 4, 3}, '{1'b1, 1'b1, 2'b11, 4, 2},
            '{1'b1, 1'b1, 2'b11, 4, 1}, '{1'b1, 1'b1, 2'b11, 4, 0},
            '{1'b1, 1'b1, 2'b11, 7, 0}, '{1'b1, 1'b0, 2'b11, 0, 0}};
        to_tick();
        for (int i = 0; i < 12; i++) begin
            tick_with(rows[i].s, rows[i].a, rows[i].t);
            n_vec++;
            if (STATE !== 3'(rows[i].st) || LED !== led_tab[rows[i].st] ||
                TIM !== TW'(rows[i].tm)) begin
                n_err++;
                $display("FAIL nominal[%0d]: got state=%0d led=%b tim=%0d, want state=%0d led=%b tim=%0d",
                         i, STATE, LED, TIM, rows[i].st, led_tab[rows[i].st], rows[i].tm);
            end
        end
    endtask

    task automatic test_abort_run();
        row_t rows [5] = '{
            '{1'b1, 1'b1, 2'b11, 4, 2}, '{1'b1, 1'b1, 2'b00, 5, 1},
            '{1'b1, 1'b0, 2'b11, 6, 0}, '{1'b0, 1'b1, 2'b11, 7, 0},
            '{1'b1, 1'b0, 2'b11, 0, 0}};
        to_tick();
        go_hold();
        tick_with(1'b1, 1'b1, 2'b11);
        for (int i = 0; i < 5; i++) begin
            tick_with(rows[i].s, rows[i].a, rows[i].t);
            n_vec++;
            if (STATE !== 3'(rows[i].st) || LED !== led_tab[rows[i].st] ||
                TIM !== TW'(rows[i].tm)) begin
                n_err++;
                $display("FAIL abort_run[%0d]: got state=%0d led=%b tim=%0d, want state=%0d led=%b tim=%0d",
                         i, STATE, LED, TIM, rows[i].st, led_tab[rows[i].st], rows[i].tm);
            end
        end
    endtask

    task automatic test_simultaneous();
        to_tick();
        go_hold();
        n_vec++;
        if (STATE !== 3'd3 || TIM !== '0) begin
            n_err++;
            $display("FAIL simul_pre: got state=%0d tim=%0d, want state=3 tim=0", STATE, TIM);
        end
        tick_with(1'b1, 1'b1, 2'b00);
        n_vec++;
        if (STATE !== 3'd4 || LED !== 4'b0111 || TIM !== TW'(3)) begin
            n_err++;
            $display("FAIL simul_expiry_wins: got state=%0d led=%b tim=%0d, want state=4 led=0111 tim=3",
                     STATE, LED, TIM);
        end
    endtask

    // Continues from RUN with TIM=3 left by test_simultaneous.
    task automatic test_reset_mid_run();
        tick_with(1'b1, 1'b1, 2'b11);
        n_vec++;
        if (STATE !== 3'd4 || TIM !== TW'(2)) begin
            n_err++;
            $display("FAIL rst_run_pre: got state=%0d tim=%0d, want state=4 tim=2", STATE, TIM);
        end
        RST_N = 1'b0;
        clk_cycle();
        RST_N = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (STATE !== 3'd0 || LED !== 4'b0000 || TIM !== '0 || TICK !== (i == 3)) begin
                n_err++;
                $display("FAIL rst_run[%0d]: got state=%0d led=%b tim=%0d tick=%b, want 0/0000/0 tick=%b",
                         i, STATE, LED, TIM, TICK, i == 3);
            end
            clk_cycle();
        end
    endtask

`ifndef SEQ_CTRL_INPUT_SYNC_EN
    task automatic test_between_ticks();
        to_tick();
        START_N = 1'b0;
        clk_cycle();
        clk_cycle();
        START_N = 1'b1;
        to_tick();
        to_tick();
        n_vec++;
        if (STATE !== 3'd0 || LED !== 4'b0000) begin
            n_err++;
            $display("FAIL between_ticks: got state=%0d led=%b, want state=0 led=0000", STATE, LED);
        end
    endtask
`else
    task automatic test_sync_latency();
        to_tick();
        for (int i = 0; i < TD - 1; i++) clk_cycle();
        START_N = 1'b0;
        to_tick();
        n_vec++;
        if (STATE !== 3'd0) begin
            n_err++;
            $display("FAIL sync_first_tick: got state=%0d, want 0", STATE);
        end
        to_tick();
        START_N = 1'b1;
        n_vec++;
        if (STATE !== 3'd1) begin
            n_err++;
            $display("FAIL sync_second_tick: got state=%0d, want 1", STATE);
        end
    endtask
`endif

    task automatic test_random();
        logic [2:0]    e_st;
        logic [TW-1:0] e_tim;
        bit            e_tick;
        for (int i = 0; i < 1600; i++) begin
            RST_N = ($urandom_range(0, 199) != 0);
            START_N = ($urandom_range(0, 5) != 0);
            ACK_N = ($urandom_range(0, 5) != 0);
            for (int j = 0; j < NT; j++) TRIG_N[j] = ($urandom_range(0, 3) != 0);
            clk_cycle();
            e_st = 3'(m_state);
            e_tim = TW'(m_tim);
            e_tick = (m_cnt == TD - 1);
            n_vec++;
            if (STATE !== e_st || LED !== led_tab[m_state] || TIM !== e_tim || TICK !== e_tick) begin
                n_err++;
                $display("FAIL random[%0d]: got state=%0d led=%b tim=%0d tick=%b, want state=%0d led=%b tim=%0d tick=%b",
                         i, STATE, LED, TIM, TICK, e_st, led_tab[m_state], e_tim, e_tick);
            end
        end
        RST_N = 1'b1; START_N = 1'b1; ACK_N = 1'b1; TRIG_N = '1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_tick_period();
        test_nominal();
        test_abort_run();
        test_simultaneous();
        test_reset_mid_run();
`ifndef SEQ_CTRL_INPUT_SYNC_EN
        test_between_ticks();
`else
        test_sync_latency();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
